mult_hilo_ctrl: RTL and testbench
=================================

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 The block SHALL have one parameter, MULT_CYCLES, default 32, giving the number of accumulate cycles the downstream multiplier needs after its load pulse.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  multiply request from the control unit; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = signed multiply, 0 = unsigned; sampled with start.
REQ-006 a_in, b_in  input  32 each  operands, sampled with start.
REQ-007 mult_start  output  1  one-cycle load pulse driving the multiplier's multControl.
REQ-008 mult_a, mult_b  output  32 each  operands presented to the multiplier.
REQ-009 mult_hi, mult_lo  input  32 each  multiplier product (high word, low word).
REQ-010 hi_wr, lo_wr  input  1 each  mthi/mtlo write strobes.
REQ-011 wr_data  input  32  data for mthi/mtlo.
REQ-012 busy  output  1  high in LAUNCH, WAIT and CAPTURE.
REQ-013 done  output  1  one-cycle pulse while in CAPTURE.
REQ-014 hi, lo  output  32 each  architectural HI and LO registers.

Function
REQ-015 The FSM SHALL have the states IDLE, LAUNCH, WAIT and CAPTURE.
REQ-016 IDLE: start=1 -> latch a_in, b_in and signed_op, then go to LAUNCH; otherwise stay in IDLE.
REQ-017 LAUNCH: mult_start=1 for exactly one cycle; load the counter with MULT_CYCLES; go to WAIT.
REQ-018 WAIT: decrement the counter every cycle; go to CAPTURE on the edge where counter==1, so the block spends exactly MULT_CYCLES cycles in WAIT.
REQ-019 CAPTURE: done=1; on the edge that leaves CAPTURE, hi/lo SHALL load the final product; the next state SHALL be IDLE.
REQ-020 Latency: if start is sampled on edge 0, done SHALL be high between edge MULT_CYCLES+1 and edge MULT_CYCLES+2, and hi/lo SHALL update on edge MULT_CYCLES+2 (edge 34 for the default).
REQ-021 mult_a and mult_b SHALL hold the latched operands, stable, from LAUNCH through CAPTURE.
REQ-022 A start pulse while busy=1 SHALL be ignored; the block SHALL NOT queue it.
REQ-023 hi_wr and lo_wr SHALL load wr_data into hi or lo only when the block is in IDLE; while busy=1 they SHALL be ignored.
REQ-024 hi_wr=1 and lo_wr=1 together SHALL load both registers with wr_data.
REQ-025 A write and a start in the same IDLE cycle SHALL both take effect: the write lands on that edge and the capture overwrites it later.
REQ-026 The product SHALL be 64 bits, with no truncation; hi = bits 63:32 and lo = bits 31:0.

Reset
REQ-027 reset=0 SHALL, asynchronously: force IDLE, clear the counter and the latched operands, and clear hi and lo to 0.
REQ-028 While reset=0, mult_start, busy and done SHALL be 0 and mult_a and mult_b SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abort it with no capture; after release the block SHALL accept a new start.

Configuration
REQ-030 The macro MULT_SIGNED_EN SHALL enable signed support.
- Defined: with signed_op=1, mult_a and mult_b are the magnitudes of the two's-complement operands, and at capture the 64-bit product is negated when the operand signs differ.
- Undefined: signed_op is ignored and every operation is unsigned (mult_a=a, mult_b=b, no correction).

Verification
REQ-031 a=3, b=5, unsigned, default parameter -> mult_start pulses once; done high during cycle 34; hi=0x00000000, lo=0x0000000F.
REQ-032 a=0xFFFFFFFF, b=0xFFFFFFFF, unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 a=0xFFFFFFFE, b=3, signed_op=1 -> with MULT_SIGNED_EN: hi=0xFFFFFFFF, lo=0xFFFFFFFA; without it: hi=0x00000002, lo=0xFFFFFFFA.
REQ-034 Start, then reset=0 at cycle 10, released at cycle 12 -> no done pulse; hi/lo stay 0; a new 7*6 start gives lo=0x0000002A.
REQ-035 hi_wr with wr_data=0x12345678 in IDLE -> hi=0x12345678; a second start plus hi_wr=0xDEADBEEF while busy -> both ignored, and hi becomes the product of the first operation only.

Source files
------------

// File: rtl/mult_hilo_ctrl_if.sv
// Bus bundle between the control unit, the iterative multiplier and the HI/LO controller.
// The slave modport is the controller's view; master is the surrounding datapath's view.
interface mult_hilo_ctrl_if;
    localparam int unsigned DATA_W = 32;

    logic              start;
    logic              signed_op;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              mult_start;
    logic [DATA_W-1:0] mult_a;
    logic [DATA_W-1:0] mult_b;
    logic [DATA_W-1:0] mult_hi;
    logic [DATA_W-1:0] mult_lo;
    logic              hi_wr;
    logic              lo_wr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport slave (
        input  start, signed_op, a_in, b_in,
        input  mult_hi, mult_lo,
        input  hi_wr, lo_wr, wr_data,
        output mult_start, mult_a, mult_b,
        output busy, done, hi, lo
    );

    modport master (
        output start, signed_op, a_in, b_in,
        output mult_hi, mult_lo,
        output hi_wr, lo_wr, wr_data,
        input  mult_start, mult_a, mult_b,
        input  busy, done, hi, lo
    );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Sequences an iterative multiplier and owns the architectural HI/LO registers.
// Define MULT_SIGNED_EN to add signed multiply (magnitude operands plus product negation).
module mult_hilo_ctrl #(
    parameter int unsigned MULT_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    mult_hilo_ctrl_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(MULT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                neg_q, neg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mult_start_q, mult_start_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [DATA_W-1:0]   mag_a_c;
    logic [DATA_W-1:0]   mag_b_c;
    logic                neg_c;
    logic [PROD_W-1:0]   raw_prod_c;
    logic [PROD_W-1:0]   prod_c;

    assign raw_prod_c = {bus.mult_hi, bus.mult_lo};

`ifdef MULT_SIGNED_EN
    // Multiplier is unsigned-only: feed magnitudes, restore the sign at capture.
    assign mag_a_c = (bus.signed_op && bus.a_in[DATA_W-1]) ? (DATA_W'(0) - bus.a_in) : bus.a_in;
    assign mag_b_c = (bus.signed_op && bus.b_in[DATA_W-1]) ? (DATA_W'(0) - bus.b_in) : bus.b_in;
    assign neg_c   = bus.signed_op && (bus.a_in[DATA_W-1] ^ bus.b_in[DATA_W-1]);
    assign prod_c  = neg_q ? (PROD_W'(0) - raw_prod_c) : raw_prod_c;
`else
    logic unused_signed_op;

    assign unused_signed_op = bus.signed_op;
    assign mag_a_c = bus.a_in;
    assign mag_b_c = bus.b_in;
    assign neg_c   = 1'b0;
    assign prod_c  = raw_prod_c;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            neg_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mult_start_q <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            neg_q        <= neg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mult_start_q <= mult_start_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        neg_d        = neg_q;
        hi_d         = hi_q;
        lo_d         = lo_q;

        case (state_q)
            ST_IDLE: begin
                // mthi/mtlo only land while idle; a same-cycle start still launches
                if (bus.hi_wr) begin
                    hi_d = bus.wr_data;
                end
                if (bus.lo_wr) begin
                    lo_d = bus.wr_data;
                end
                if (bus.start) begin
                    op_a_d  = mag_a_c;
                    op_b_d  = mag_b_c;
                    neg_d   = neg_c;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = CNT_W'(MULT_CYCLES);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                hi_d    = prod_c[PROD_W-1:DATA_W];
                lo_d    = prod_c[DATA_W-1:0];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags are registered from the upcoming state so they align with it
        busy_d       = (state_d != ST_IDLE);
        mult_start_d = (state_d == ST_LAUNCH);
        done_d       = (state_d == ST_CAPTURE);
    end

    assign bus.mult_start = mult_start_q;
    assign bus.mult_a     = op_a_q;
    assign bus.mult_b     = op_b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl: operation-level model, cycle compare and
// literal checks of the documented example products. Honours MULT_SIGNED_EN.
module tb_mult_hilo_ctrl;
    localparam int unsigned M = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mult_hilo_ctrl_if bus();

    mult_hilo_ctrl #(.MULT_CYCLES(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    bit done_seen = 1'b0;
    int ms_cnt    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the operation definition
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        longint p;
        sa = a;
        sb = b;
        p  = longint'(sa) * longint'(sb);
`ifdef MULT_SIGNED_EN
        if (s) return 64'(p);
`else
        if (s && p == 0) return 64'd0;
`endif
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] x, input logic s);
`ifdef MULT_SIGNED_EN
        if (s && x[31]) return 32'd0 - x;
`else
        if (s && x == 32'd0) return 32'd0;
`endif
        return x;
    endfunction

    // Multiplier stand-in: garbage while accumulating, true product once M cycles elapse
    int mcnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt        <= 0;
            bus.mult_hi <= 32'hA5A5_A5A5;
            bus.mult_lo <= 32'h5A5A_5A5A;
        end else if (bus.mult_start) begin
            mcnt        <= M;
            bus.mult_hi <= 32'hBAD0_BAD0;
            bus.mult_lo <= 32'h0BAD_0BAD;
        end else if (mcnt == 1) begin
            mcnt <= 0;
            {bus.mult_hi, bus.mult_lo} <= {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end
    end

    // Operation-level model: an accepted start owns the block for M+2 edges
    bit          m_active;
    int          m_age;
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [63:0] m_prod;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_age    = 0;
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            m_a      = 32'd0;
            m_b      = 32'd0;
            m_prod   = 64'd0;
        end else if (!m_active) begin
            if (bus.hi_wr) m_hi = bus.wr_data;
            if (bus.lo_wr) m_lo = bus.wr_data;
            if (bus.start) begin
                m_active = 1'b1;
                m_age    = 0;
                m_a      = ref_mag(bus.a_in, bus.signed_op);
                m_b      = ref_mag(bus.b_in, bus.signed_op);
                m_prod   = ref_prod(bus.a_in, bus.b_in, bus.signed_op);
            end
        end else begin
            m_age++;
            if (m_age == M + 2) begin
                m_hi     = m_prod[63:32];
                m_lo     = m_prod[31:0];
                m_active = 1'b0;
            end
        end
    end

    // Cycle compare against the model
    always @(posedge clk) begin
        #1;
        chk1("busy", bus.busy, m_active);
        chk1("done", bus.done, m_active && m_age == M + 1);
        chk1("mult_start", bus.mult_start, m_active && m_age == 0);
        chk32("hi", bus.hi, m_hi);
        chk32("lo", bus.lo, m_lo);
        if (m_active) begin
            chk32("mult_a", bus.mult_a, m_a);
            chk32("mult_b", bus.mult_b, m_b);
        end
        if (!reset) begin
            chk32("mult_a_rst", bus.mult_a, 32'd0);
            chk32("mult_b_rst", bus.mult_b, 32'd0);
        end
        if (bus.done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (bus.mult_start) ms_cnt++;
    end

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a_in      = a;
        bus.b_in      = b;
        bus.signed_op = s;
        start_cyc     = cyc + 1;
        done_seen     = 1'b0;
        ms_cnt        = 0;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        drive_start(a, b, s);
        repeat (M + 4) @(negedge clk);
        chk1("done_seen", done_seen, 1'b1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.a_in      = 32'd0;
        bus.b_in      = 32'd0;
        bus.hi_wr     = 1'b0;
        bus.lo_wr     = 1'b0;
        bus.wr_data   = 32'd0;

        repeat (3) @(negedge clk);
        chk32("rst_hi", bus.hi, 32'd0);
        chk32("rst_lo", bus.lo, 32'd0);
        chk1("rst_busy", bus.busy, 1'b0);
        reset = 1'b1;

        // 3*5 unsigned, with latency pinned
        run_op(32'd3, 32'd5, 1'b0);
        chk32("p3x5_hi", bus.hi, 32'h0000_0000);
        chk32("p3x5_lo", bus.lo, 32'h0000_000F);
        chk32("p3x5_mstart_cnt", 32'(ms_cnt), 32'd1);
        chk32("p3x5_done_lat", 32'(done_cyc - start_cyc), 32'd33);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk32("pmax_hi", bus.hi, 32'hFFFF_FFFE);
        chk32("pmax_lo", bus.lo, 32'h0000_0001);

        run_op(32'hFFFF_FFFE, 32'd3, 1'b1);
`ifdef MULT_SIGNED_EN
        chk32("pneg_hi", bus.hi, 32'hFFFF_FFFF);
`else
        chk32("pneg_hi", bus.hi, 32'h0000_0002);
`endif
        chk32("pneg_lo", bus.lo, 32'hFFFF_FFFA);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        chk32("pmin_hi", bus.hi, 32'h4000_0000);
        chk32("pmin_lo", bus.lo, 32'h0000_0000);

        // mthi in idle, then start+mthi while busy are both dropped
        @(negedge clk);
        bus.hi_wr = 1'b1; bus.wr_data = 32'h1234_5678;
        @(negedge clk);
        bus.hi_wr = 1'b0;
        chk32("mthi_idle", bus.hi, 32'h1234_5678);
        drive_start(32'h0001_0000, 32'h0003_0000, 1'b0);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.a_in = 32'd99; bus.b_in = 32'd99;
        bus.hi_wr = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_wr = 1'b0;
        repeat (M + 2) @(negedge clk);
        chk32("busy_ign_hi", bus.hi, 32'h0000_0003);
        chk32("busy_ign_lo", bus.lo, 32'h0000_0000);
        chk32("busy_ign_mstart_cnt", 32'(ms_cnt), 32'd1);
        chk1("busy_ign_idle", bus.busy, 1'b0);

        // Dual write, then write racing a start
        @(negedge clk);
        bus.hi_wr = 1'b1; bus.lo_wr = 1'b1; bus.wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        bus.hi_wr = 1'b0; bus.lo_wr = 1'b0;
        chk32("dual_hi", bus.hi, 32'hCAFE_F00D);
        chk32("dual_lo", bus.lo, 32'hCAFE_F00D);
        bus.lo_wr = 1'b1; bus.wr_data = 32'h0000_0055;
        drive_start(32'd2, 32'd4, 1'b0);
        bus.lo_wr = 1'b0;
        chk32("wr_start_lo", bus.lo, 32'h0000_0055);
        chk1("wr_start_busy", bus.busy, 1'b1);
        repeat (M + 4) @(negedge clk);
        chk32("wr_start_cap_lo", bus.lo, 32'h0000_0008);
        chk32("wr_start_cap_hi", bus.hi, 32'h0000_0000);

        // Reset mid-operation aborts without capture
        drive_start(32'd9, 32'd9, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk1("abort_busy", bus.busy, 1'b0);
        repeat (M + 4) @(negedge clk);
        chk1("abort_no_done", done_seen, 1'b0);
        chk32("abort_hi", bus.hi, 32'd0);
        chk32("abort_lo", bus.lo, 32'd0);
        run_op(32'd7, 32'd6, 1'b0);
        chk32("after_abort_lo", bus.lo, 32'h0000_002A);
        chk32("after_abort_hi", bus.hi, 32'h0000_0000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
